// File: rtl/fetch_entry_queue_pkg.sv
// Shared types for the fetch-entry queue: core config, branch-predict and exception
// payloads, the decode-facing fetch entry, and the realigner state encoding.
package fetch_entry_queue_pkg;

    localparam int unsigned VLEN = 32;

    typedef struct packed {
        int unsigned VLEN;
        bit          RVC;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32, RVC: 1'b1};

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        cf_t             cf;
        logic [VLEN-1:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic            valid;
        logic [3:0]      cause;
        logic [VLEN-1:0] tval;
    } frontend_exception_t;

    typedef struct packed {
        logic [VLEN-1:0]     address;
        logic [31:0]         instruction;
        branchpredict_sbe_t  branch_predict;
        frontend_exception_t ex;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ALIGNED,
        SECOND_HALF,
        STRADDLE
    } realign_state_e;

    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_entry_realigner.sv
// Splits 32-bit fetch words into RVC/RV32 instructions, one entry per cycle, holding the
// upper half of a word when a 32-bit instruction straddles into the next word.
module fetch_entry_realigner
    import fetch_entry_queue_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                room_i,
    input  logic                fetch_valid_i,
    input  logic [31:0]         fetch_data_i,
    input  logic [VLEN-1:0]     fetch_addr_i,
    input  branchpredict_sbe_t  fetch_bp_i,
    input  frontend_exception_t fetch_ex_i,
    output logic                fetch_ready_o,
    output logic                push_o,
    output fetch_entry_t        entry_o
);

    realign_state_e  state_q, state_d;
    logic [15:0]     hi_q, hi_d;
    logic [VLEN-1:0] haddr_q, haddr_d;

    logic [15:0]     lo, hi;
    logic [VLEN-1:0] upper_addr;
    logic            advance, upper_phase;

    assign lo          = fetch_data_i[15:0];
    assign hi          = fetch_data_i[31:16];
    assign upper_addr  = {fetch_addr_i[VLEN-1:2], 2'b10};
    assign advance     = fetch_valid_i && room_i && !rst_i && !flush_i;
    // A word entering at an odd halfword is handled exactly like the held upper half.
    assign upper_phase = (state_q == SECOND_HALF) || (state_q == ALIGNED && fetch_addr_i[1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ALIGNED;
            hi_q    <= '0;
            haddr_q <= '0;
        end else begin
            state_q <= flush_i ? ALIGNED : state_d;
            hi_q    <= hi_d;
            haddr_q <= haddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        haddr_d = haddr_q;
        if (advance) begin
            if (fetch_ex_i.valid || !CVA6Cfg.RVC) begin
                state_d = ALIGNED;
            end else if (state_q == STRADDLE) begin
                state_d = SECOND_HALF;
            end else if (upper_phase) begin
                if (is_compressed(hi)) begin
                    state_d = ALIGNED;
                end else begin
                    state_d = STRADDLE;
                    hi_d    = hi;
                    haddr_d = upper_addr;
                end
            end else if (is_compressed(lo)) begin
                if (is_compressed(hi)) begin
                    state_d = SECOND_HALF;
                end else begin
                    state_d = STRADDLE;
                    hi_d    = hi;
                    haddr_d = upper_addr;
                end
            end else begin
                state_d = ALIGNED;
            end
        end
    end

    always_comb begin
        push_o        = 1'b0;
        fetch_ready_o = 1'b0;
        entry_o       = '0;
        entry_o.ex    = fetch_ex_i;
        if (advance) begin
            if (fetch_ex_i.valid) begin
                push_o                 = 1'b1;
                fetch_ready_o          = 1'b1;
                entry_o.address        = (state_q == STRADDLE) ? haddr_q : fetch_addr_i;
                entry_o.instruction    = fetch_data_i;
                entry_o.branch_predict = fetch_bp_i;
                if (state_q == STRADDLE) entry_o.ex.tval = fetch_addr_i;
            end else if (!CVA6Cfg.RVC) begin
                push_o                 = 1'b1;
                fetch_ready_o          = 1'b1;
                entry_o.address        = fetch_addr_i;
                entry_o.instruction    = fetch_data_i;
                entry_o.branch_predict = fetch_bp_i;
            end else if (state_q == STRADDLE) begin
                // The straddler is the word's last instruction only if the upper half opens another one.
                push_o              = 1'b1;
                entry_o.address     = haddr_q;
                entry_o.instruction = {lo, hi_q};
                if (!is_compressed(hi)) entry_o.branch_predict = fetch_bp_i;
            end else if (upper_phase) begin
                fetch_ready_o = 1'b1;
                if (is_compressed(hi)) begin
                    push_o                 = 1'b1;
                    entry_o.address        = upper_addr;
                    entry_o.instruction    = {16'h0, hi};
                    entry_o.branch_predict = fetch_bp_i;
                end
            end else if (is_compressed(lo)) begin
                push_o              = 1'b1;
                fetch_ready_o       = !is_compressed(hi);
                entry_o.address     = fetch_addr_i;
                entry_o.instruction = {16'h0, lo};
                if (!is_compressed(hi)) entry_o.branch_predict = fetch_bp_i;
            end else begin
                push_o                 = 1'b1;
                fetch_ready_o          = 1'b1;
                entry_o.address        = fetch_addr_i;
                entry_o.instruction    = fetch_data_i;
                entry_o.branch_predict = fetch_bp_i;
            end
        end
    end

endmodule

// File: rtl/fetch_entry_queue.sv
// Realigned fetch-entry FIFO feeding decode. Define FETCH_QUEUE_BYPASS_EN to let an entry
// skip the empty FIFO when decode is ready in the same cycle.
module fetch_entry_queue
    import fetch_entry_queue_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                fetch_valid_i,
    output logic                fetch_ready_o,
    input  logic [31:0]         fetch_data_i,
    input  logic [VLEN-1:0]     fetch_addr_i,
    input  branchpredict_sbe_t  fetch_bp_i,
    input  frontend_exception_t fetch_ex_i,
    output fetch_entry_t        fetch_entry_o,
    output logic                fetch_entry_valid_o,
    input  logic                fetch_entry_ready_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;

    fetch_entry_t new_entry;
    logic         empty, full, pop, push, write, has_room, bypass;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = fetch_entry_ready_i && !empty;
    assign has_room = !full || pop;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && push && fetch_entry_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign write = push && !bypass;

    fetch_entry_realigner #(
        .CVA6Cfg(CVA6Cfg)
    ) u_realigner (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .room_i       (has_room),
        .fetch_valid_i(fetch_valid_i),
        .fetch_data_i (fetch_data_i),
        .fetch_addr_i (fetch_addr_i),
        .fetch_bp_i   (fetch_bp_i),
        .fetch_ex_i   (fetch_ex_i),
        .fetch_ready_o(fetch_ready_o),
        .push_o       (push),
        .entry_o      (new_entry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (write) wptr_q <= wptr_q + 1'b1;
            if (pop)   rptr_q <= rptr_q + 1'b1;
            case ({write, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (write) mem_q[wptr_q] <= new_entry;
    end

    always_comb begin
        fetch_entry_valid_o = 1'b0;
        fetch_entry_o       = '0;
        if (!rst_i) begin
            if (bypass) begin
                fetch_entry_valid_o = 1'b1;
                fetch_entry_o       = new_entry;
            end else if (!empty) begin
                fetch_entry_valid_o = 1'b1;
                fetch_entry_o       = mem_q[rptr_q];
            end
        end
    end

endmodule
